// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone-mapped 8N1 UART transmitter with a byte FIFO, a programmable
// baud divisor and a level interrupt that fires once the transmitter has drained.
//
//   state | meaning
//   IDLE  | line high, waiting for the FIFO to hold a byte
//   START | driving the start bit (0)
//   DATA  | driving data bits, LSB first
//   STOP  | driving the stop bit (1)
module wb_uart_tx #(
  parameter int XLEN       = 32,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_adr,
  input  logic [XLEN/8-1:0] wb_sel,
  input  logic [XLEN-1:0]   wb_dat_w,
  output logic [XLEN-1:0]   wb_dat_r,
  output logic              wb_ack,
  output logic              tx,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow, irq_en;
  logic [15:0]     div;
  logic [15:0]     bit_cnt, bit_cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            tx_nxt, pop;
  logic            req, push_req, push, fifo_full, fifo_empty;
  logic [15:0]     reload;
  logic [3:0]      cnt_field;
  logic [XLEN-1:0] rd_mux;
  logic            unused_bits;

  assign unused_bits = ^{wb_adr[XLEN-1:4], wb_adr[1:0], wb_dat_w[XLEN-1:16], wb_sel[XLEN/8-1:2]};

  assign req        = wb_cyc & wb_stb & ~wb_ack;
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = req & wb_we & (wb_adr[3:2] == 2'd0) & wb_sel[0];
  // A full FIFO still accepts a push when the serialiser pops on the same edge.
  assign push       = push_req & (~fifo_full | pop);
  // Divisor 0 behaves as 1, i.e. the counter reloads with 0.
  assign reload     = (div == 16'd0) ? 16'd0 : div - 16'd1;

  always_comb begin
    cnt_field = 4'hf;
    if (32'(count) < 32'd16) cnt_field = 4'(count);
  end

  always_comb begin
    rd_mux = '0;
    case (wb_adr[3:2])
      2'd1:    rd_mux[7:0]  = {cnt_field, overflow, state != IDLE, fifo_empty, fifo_full};
      2'd2:    rd_mux[15:0] = div;
      2'd3:    rd_mux[0]    = irq_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_r <= '0;
      overflow <= 1'b0;
      div      <= 16'(CLK_DIV);
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      wb_ack <= req;
      irq    <= irq_en & fifo_empty & (state == IDLE);
      if (req) wb_dat_r <= wb_we ? '0 : rd_mux;
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      if (req && wb_we) begin
        case (wb_adr[3:2])
          2'd1: if (wb_sel[0] && wb_dat_w[3]) overflow <= 1'b0;
          2'd2: begin
            if (wb_sel[0]) div[7:0]  <= wb_dat_w[7:0];
            if (wb_sel[1]) div[15:8] <= wb_dat_w[15:8];
          end
          2'd3: if (wb_sel[0]) irq_en <= wb_dat_w[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wb_dat_w[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_nxt   = fifo_mem[rd_ptr];
          bit_cnt_nxt = reload;
          tx_nxt      = 1'b0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_cnt == 16'd0) begin
          tx_nxt      = shift[0];
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = 3'd0;
          bit_cnt_nxt = reload;
          state_nxt   = DATA;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == 16'd0) begin
          bit_cnt_nxt = reload;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt      = shift[0];
            shift_nxt   = {1'b0, shift[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt == 16'd0) state_nxt = IDLE;
        else                  bit_cnt_nxt = bit_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule
